lcd_msg_scheduler: RTL

LCD_MSG_SCHEDULER -- requirements
Module: lcd_msg_scheduler

---
 rtl/lcd_pkg.sv | 54 +++++
 rtl/lcd_msg_rom.sv | 61 ++++++
 rtl/lcd_msg_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD message scheduler: message ids, init commands,
// frame layout and the fixed 16-character line texts.
package lcd_pkg;

    localparam logic [1:0] MSG_ENTER  = 2'd0;
    localparam logic [1:0] MSG_KEY    = 2'd1;
    localparam logic [1:0] MSG_OPEN   = 2'd2;
    localparam logic [1:0] MSG_FREEZE = 2'd3;

    localparam int         FRAME_LEN    = 34;
    localparam logic [5:0] LAST_IDX     = 6'(FRAME_LEN - 1);
    localparam logic [5:0] LINE2_IDX    = 6'd17;
    localparam logic [2:0] INIT_LAST    = 3'd4;
    localparam logic [3:0] KEY_CHAR_POS = 4'd12;

    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // Index 0 of each line is the left-most character (most significant byte).
    localparam logic [127:0] TXT_ENTER   = "ENTER PASSWORD  ";
    localparam logic [127:0] TXT_BLANK   = "                ";
    localparam logic [127:0] TXT_KEY     = "KEY VALUE : X   ";
    localparam logic [127:0] TXT_OPEN    = "      OPEN      ";
    localparam logic [127:0] TXT_FREEZE1 = "   !! FREEZE !! ";
    localparam logic [127:0] TXT_FREEZE2 = "   TRY LATER    ";

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND
`ifdef LCD_MIN_HOLD_EN
        , ST_HOLD
`endif
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h0E;
            3'd3:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    function automatic logic [7:0] txt_char(input logic [127:0] s, input logic [3:0] pos);
        return s[{~pos, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational frame ROM: maps (message, byte index, key character) to the
// {rs, data} pair for that position of a 34-byte frame.
module lcd_msg_rom
    import lcd_pkg::*;
(
    input  logic [1:0] msg_i,
    input  logic [5:0] idx_i,
    input  logic [7:0] key_ascii_i,
    output logic       rs_o,
    output logic [7:0] data_o
);

    logic [127:0] line1;
    logic [127:0] line2;
    logic [3:0]   pos1;
    logic [3:0]   pos2;

    // Low nibble arithmetic wraps correctly for indices 1..16 and 18..33.
    assign pos1 = idx_i[3:0] - 4'd1;
    assign pos2 = idx_i[3:0] - 4'd2;

    always_comb begin
        line1 = TXT_ENTER;
        line2 = TXT_BLANK;
        case (msg_i)
            MSG_KEY: begin
                line1 = TXT_ENTER;
                line2 = TXT_KEY;
            end
            MSG_OPEN: begin
                line1 = TXT_OPEN;
                line2 = TXT_BLANK;
            end
            MSG_FREEZE: begin
                line1 = TXT_FREEZE1;
                line2 = TXT_FREEZE2;
            end
            default: ;
        endcase
    end

    always_comb begin
        rs_o   = 1'b1;
        data_o = 8'h20;
        if (idx_i == 6'd0) begin
            rs_o   = 1'b0;
            data_o = CMD_LINE1;
        end else if (idx_i < LINE2_IDX) begin
            data_o = txt_char(line1, pos1);
        end else if (idx_i == LINE2_IDX) begin
            rs_o   = 1'b0;
            data_o = CMD_LINE2;
        end else if (idx_i <= LAST_IDX) begin
            if (msg_i == MSG_KEY && pos2 == KEY_CHAR_POS)
                data_o = key_ascii_i;
            else
                data_o = txt_char(line2, pos2);
        end
    end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Priority-driven LCD message scheduler: runs the controller init sequence,
// then redraws 34-byte frames when the selected message changes.
// Optional minimum-display hold is enabled by defining LCD_MIN_HOLD_EN.
//
//   state | meaning
//   INIT  | sending the five controller setup commands
//   IDLE  | frame on display, waiting for a selection change or redraw
//   SEND  | streaming the snapshotted frame to the bus driver
//   HOLD  | minimum display time; only higher priority or KEY redraws start
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 24000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       frozen_req,
    input  logic       open_req,
    input  logic       key_req,
    input  logic [3:0] key_value,
    output logic       wr_valid,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       busy,
    output logic [1:0] cur_msg
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

    state_t     state_q;
    logic [2:0] init_idx_q;
    logic [5:0] idx_q;
    logic [1:0] frame_msg_q;
    logic [7:0] frame_key_q;
    logic [1:0] cur_msg_q;
    logic [3:0] key_val_q;
    logic       key_seen_q;
    logic       pending_q;
    logic       wr_valid_q;
    logic       wr_rs_q;
    logic [7:0] wr_data_q;
    logic       busy_q;

    logic [1:0] sel;
    logic       start;
    logic       xfer;
    logic       rom_rs;
    logic [7:0] rom_data;

`ifdef LCD_MIN_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [HW-1:0] hold_cnt_q;
`endif

    assign xfer = wr_valid_q & wr_ready;

    always_comb begin
        if (frozen_req)
            sel = MSG_FREEZE;
        else if (open_req)
            sel = MSG_OPEN;
        else if (key_seen_q)
            sel = MSG_KEY;
        else
            sel = MSG_ENTER;
    end

    // Message ids are ordered by priority, so a numeric compare ranks them.
    always_comb begin
        start = 1'b0;
        if (state_q == ST_IDLE)
            start = (sel != cur_msg_q) | pending_q;
`ifdef LCD_MIN_HOLD_EN
        else if (state_q == ST_HOLD)
            start = (sel > cur_msg_q) | (pending_q & (sel == cur_msg_q));
`endif
    end

    lcd_msg_rom u_rom (
        .msg_i       (frame_msg_q),
        .idx_i       (idx_q + 6'd1),
        .key_ascii_i (frame_key_q),
        .rs_o        (rom_rs),
        .data_o      (rom_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            init_idx_q  <= 3'd0;
            idx_q       <= 6'd0;
            frame_msg_q <= MSG_ENTER;
            frame_key_q <= 8'h30;
            cur_msg_q   <= MSG_ENTER;
            key_val_q   <= 4'd0;
            key_seen_q  <= 1'b0;
            pending_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_rs_q     <= 1'b0;
            wr_data_q   <= 8'h00;
            busy_q      <= 1'b1;
`ifdef LCD_MIN_HOLD_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            if (key_req) begin
                key_seen_q <= 1'b1;
                key_val_q  <= key_value;
            end
            // A key arriving on the start cycle misses the snapshot, so it stays pending.
            pending_q <= (pending_q & ~start) | key_req;

            if (start) begin
                frame_msg_q <= sel;
                frame_key_q <= hex_ascii(key_val_q);
                idx_q       <= 6'd0;
                wr_valid_q  <= 1'b1;
                wr_rs_q     <= 1'b0;
                wr_data_q   <= CMD_LINE1;
                busy_q      <= 1'b1;
                state_q     <= ST_SEND;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (!wr_valid_q) begin
                            wr_valid_q <= 1'b1;
                            wr_rs_q    <= 1'b0;
                            wr_data_q  <= init_cmd(init_idx_q);
                        end else if (wr_ready) begin
                            if (init_idx_q == INIT_LAST) begin
                                frame_msg_q <= MSG_ENTER;
                                frame_key_q <= hex_ascii(key_val_q);
                                idx_q       <= 6'd0;
                                wr_data_q   <= CMD_LINE1;
                                state_q     <= ST_SEND;
                            end else begin
                                init_idx_q <= init_idx_q + 3'd1;
                                wr_data_q  <= init_cmd(init_idx_q + 3'd1);
                            end
                        end
                    end
                    ST_SEND: begin
                        if (xfer) begin
                            if (idx_q == LAST_IDX) begin
                                wr_valid_q <= 1'b0;
                                cur_msg_q  <= frame_msg_q;
                                busy_q     <= 1'b0;
`ifdef LCD_MIN_HOLD_EN
                                hold_cnt_q <= HW'(HOLD_CYCLES - 1);
                                state_q    <= ST_HOLD;
`else
                                state_q    <= ST_IDLE;
`endif
                            end else begin
                                idx_q     <= idx_q + 6'd1;
                                wr_rs_q   <= rom_rs;
                                wr_data_q <= rom_data;
                            end
                        end
                    end
`ifdef LCD_MIN_HOLD_EN
                    ST_HOLD: begin
                        if (hold_cnt_q == '0)
                            state_q <= ST_IDLE;
                        else
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_rs    = wr_rs_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign cur_msg  = cur_msg_q;

endmodule
